tdm_demux4: RTL and testbench

TDM_DEMUX4 -- requirements
Module: tdm_demux4

---
 rtl/tdm_demux4.sv | 150 +++++++++++++++
 tb/tb_tdm_demux4.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// tdm_demux4: rebuilds a 4-lane word from a 4:1 TDM serial link, one lane per valid beat.
// A beat with sync=1 is always lane 0. Define TDM_DEMUX_PARITY_EN to expect one extra
// even-parity beat after lane 3; without it parity_err is tied low.
module tdm_demux4 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [WIDTH-1:0]     din,
   input  logic                 din_valid,
   input  logic                 sync,
   output logic [1:0]           S,
   output logic [4*WIDTH-1:0]   Y,
   output logic                 y_valid,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int unsigned YW = 4 * WIDTH;

`ifdef TDM_DEMUX_PARITY_EN
   // Lane 3 is held too, so the word is complete while the parity beat is awaited.
   localparam int unsigned NLANE = 4;
   typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_e;
`else
   // Lane 3 is taken straight from din on its own beat, so only three lanes are stored.
   localparam int unsigned NLANE = 3;
   typedef enum logic [0:0] {IDLE, COLLECT} state_e;
`endif

   state_e                        state_q, state_d;
   logic [1:0]                    s_q, s_d;
   logic [NLANE-1:0][WIDTH-1:0]   lane_q, lane_d;
   logic [YW-1:0]                 y_q, y_d;
   logic                          y_valid_q, y_valid_d;
   logic                          frame_err_q, frame_err_d;
`ifdef TDM_DEMUX_PARITY_EN
   logic                          parity_err_q, parity_err_d;
`endif

   // Next-state logic: one step per valid beat; invalid cycles change nothing but the pulses.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      lane_d      = lane_q;
      y_d         = y_q;
      y_valid_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err_d = 1'b0;
`endif
      if (din_valid) begin
         case (state_q)
            IDLE: begin
               if (sync) begin
                  lane_d    = '0;
                  lane_d[0] = din;
                  s_d       = 2'd1;
                  state_d   = COLLECT;
               end
            end
            COLLECT: begin
               if (sync) begin
                  // Sync in mid-frame: drop the partial frame and restart at lane 0.
                  frame_err_d = 1'b1;
                  lane_d      = '0;
                  lane_d[0]   = din;
                  s_d         = 2'd1;
               end else if (s_q == 2'd3) begin
`ifdef TDM_DEMUX_PARITY_EN
                  lane_d[3] = din;
                  s_d       = 2'd0;
                  state_d   = PARITY;
`else
                  y_d       = {din, lane_q};
                  y_valid_d = 1'b1;
                  s_d       = 2'd0;
                  state_d   = IDLE;
`endif
               end else begin
                  for (int unsigned k = 1; k < NLANE; k++) begin
                     if (s_q == 2'(k)) lane_d[k] = din;
                  end
                  s_d = s_q + 2'd1;
               end
            end
`ifdef TDM_DEMUX_PARITY_EN
            PARITY: begin
               if (sync) begin
                  frame_err_d = 1'b1;
                  lane_d      = '0;
                  lane_d[0]   = din;
                  s_d         = 2'd1;
                  state_d     = COLLECT;
               end else begin
                  if (din[0] == (^lane_q)) begin
                     y_d       = lane_q;
                     y_valid_d = 1'b1;
                  end else begin
                     parity_err_d = 1'b1;
                  end
                  s_d     = 2'd0;
                  state_d = IDLE;
               end
            end
`endif
            default: begin
               state_d = IDLE;
               s_d     = 2'd0;
            end
         endcase
      end
   end

   // State, lane and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         s_q         <= 2'd0;
         lane_q      <= '0;
         y_q         <= '0;
         y_valid_q   <= 1'b0;
         frame_err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
         parity_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         lane_q      <= lane_d;
         y_q         <= y_d;
         y_valid_q   <= y_valid_d;
         frame_err_q <= frame_err_d;
`ifdef TDM_DEMUX_PARITY_EN
         parity_err_q <= parity_err_d;
`endif
      end
   end

   assign S         = s_q;
   assign Y         = y_q;
   assign y_valid   = y_valid_q;
   assign frame_err = frame_err_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign parity_err = parity_err_q;
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed vector table, reset sequence, then random beats against a queue model.
module tb_tdm_demux4;

   localparam int unsigned W  = 1;
   localparam int unsigned YW = 4 * W;
`ifdef TDM_DEMUX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  din = '0;
   logic          din_valid = 1'b0;
   logic          sync = 1'b0;
   logic [1:0]    s_o;
   logic [YW-1:0] y_o;
   logic          y_valid, frame_err, parity_err;

   int n_checks = 0;
   int n_fail   = 0;

   tdm_demux4 #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .din        (din),
      .din_valid  (din_valid),
      .sync       (sync),
      .S          (s_o),
      .Y          (y_o),
      .y_valid    (y_valid),
      .frame_err  (frame_err),
      .parity_err (parity_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          v;
      logic          s;
      logic [W-1:0]  d;
      logic [1:0]    es;
      logic [YW-1:0] ey;
      logic          eyv;
      logic          efe;
      logic          epe;
   } vec_t;

   vec_t tbl[$];

   // Reference model: beats of the current frame since its sync, in arrival order.
   logic [W-1:0]  m_buf[$];
   logic [YW-1:0] m_y;
   logic          m_yv, m_fe, m_pe;

   function automatic void add(input logic v, input logic s, input logic [W-1:0] d,
                               input logic [1:0] es, input logic [YW-1:0] ey,
                               input logic eyv, input logic efe, input logic epe);
      vec_t e;
      e.v = v; e.s = s; e.d = d; e.es = es; e.ey = ey;
      e.eyv = eyv; e.efe = efe; e.epe = epe;
      tbl.push_back(e);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] es, input logic [YW-1:0] ey,
                          input logic eyv, input logic efe, input logic epe);
      chk({tag, ".S"}, 32'(s_o), 32'(es));
      chk({tag, ".Y"}, 32'(y_o), 32'(ey));
      chk({tag, ".y_valid"}, 32'(y_valid), 32'(eyv));
      chk({tag, ".frame_err"}, 32'(frame_err), 32'(efe));
      chk({tag, ".parity_err"}, 32'(parity_err), 32'(epe));
   endtask

   // Present one cycle of inputs and sample just after the capturing edge.
   task automatic beat(input logic v, input logic s, input logic [W-1:0] d);
      @(negedge clk);
      din_valid = v;
      sync      = s;
      din       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic mstep(input logic v, input logic s, input logic [W-1:0] d);
      logic [YW-1:0] w;
      m_yv = 1'b0; m_fe = 1'b0; m_pe = 1'b0;
      if (!v) return;
      if (s) begin
         if (m_buf.size() != 0) m_fe = 1'b1;
         m_buf.delete();
         m_buf.push_back(d);
         return;
      end
      if (m_buf.size() == 0) return;
      if (m_buf.size() == 4) begin
         for (int k = 0; k < 4; k++) w[k*W +: W] = m_buf[k];
         if (d[0] == (^w)) begin
            m_y = w; m_yv = 1'b1;
         end else begin
            m_pe = 1'b1;
         end
         m_buf.delete();
         return;
      end
      m_buf.push_back(d);
      if (m_buf.size() == 4 && !PAR) begin
         for (int k = 0; k < 4; k++) w[k*W +: W] = m_buf[k];
         m_y  = w;
         m_yv = 1'b1;
         m_buf.delete();
      end
   endtask

   initial begin
`ifdef TDM_DEMUX_PARITY_EN
      add(1,1,1'b0, 2'd1, 4'b0000, 0,0,0);
      add(1,0,1'b1, 2'd2, 4'b0000, 0,0,0);
      add(1,0,1'b0, 2'd3, 4'b0000, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b0000, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b1010, 1,0,0);  // good parity
      add(1,1,1'b1, 2'd1, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd2, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd3, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b1010, 0,0,1);  // bad parity, Y held
      add(1,1,1'b1, 2'd1, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd2, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd3, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b1010, 0,0,0);
      add(1,1,1'b0, 2'd1, 4'b1010, 0,1,0);  // sync on parity beat
      add(1,0,1'b1, 2'd2, 4'b1010, 0,0,0);
      add(0,1,1'b1, 2'd2, 4'b1010, 0,0,0);  // gap
      add(1,0,1'b0, 2'd3, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b1010, 1,0,0);
      add(1,0,1'b1, 2'd0, 4'b1010, 0,0,0);  // non-sync in idle ignored
`else
      add(1,1,1'b0, 2'd1, 4'b0000, 0,0,0);
      add(1,0,1'b1, 2'd2, 4'b0000, 0,0,0);
      add(1,0,1'b0, 2'd3, 4'b0000, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b1010, 1,0,0);
      add(1,1,1'b1, 2'd1, 4'b1010, 0,0,0);  // back-to-back frame
      add(1,0,1'b0, 2'd2, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd3, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b0101, 1,0,0);
      add(0,1,1'b1, 2'd0, 4'b0101, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b0101, 0,0,0);  // non-sync in idle ignored
      add(1,1,1'b0, 2'd1, 4'b0101, 0,0,0);
      add(1,0,1'b1, 2'd2, 4'b0101, 0,0,0);
      add(0,0,1'b0, 2'd2, 4'b0101, 0,0,0);  // 3-cycle gap
      add(0,1,1'b1, 2'd2, 4'b0101, 0,0,0);
      add(0,0,1'b1, 2'd2, 4'b0101, 0,0,0);
      add(1,0,1'b0, 2'd3, 4'b0101, 0,0,0);
      add(1,0,1'b1, 2'd0, 4'b1010, 1,0,0);
      add(1,1,1'b1, 2'd1, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd2, 4'b1010, 0,0,0);
      add(1,1,1'b0, 2'd1, 4'b1010, 0,1,0);  // sync on third beat
      add(1,0,1'b1, 2'd2, 4'b1010, 0,0,0);
      add(1,0,1'b1, 2'd3, 4'b1010, 0,0,0);
      add(1,0,1'b0, 2'd0, 4'b0110, 1,0,0);
`endif

      // Reset state
      #3;
      chk_all("reset", 2'd0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("release", 2'd0, '0, 1'b0, 1'b0, 1'b0);

      // Directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         beat(tbl[i].v, tbl[i].s, tbl[i].d);
         chk_all($sformatf("vec%0d", i), tbl[i].es, tbl[i].ey, tbl[i].eyv, tbl[i].efe, tbl[i].epe);
      end

      // Reset mid-frame clears everything at once; non-sync beats afterwards are ignored
      beat(1, 1, 1'b1);
      beat(1, 0, 1'b1);
      chk("midframe.S", 32'(s_o), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all("async_rst", 2'd0, '0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      din_valid = 1'b0;
      sync      = 1'b0;
      rst_n     = 1'b1;
      beat(1, 0, 1'b1);
      chk_all("post_rst0", 2'd0, '0, 1'b0, 1'b0, 1'b0);
      beat(1, 0, 1'b0);
      chk_all("post_rst1", 2'd0, '0, 1'b0, 1'b0, 1'b0);

      // Random beats against the model
      m_buf.delete();
      m_y = '0;
      for (int i = 0; i < 800; i++) begin
         logic v, s;
         logic [W-1:0] d;
         v = ($urandom % 4) != 0;
         s = ($urandom % 6) == 0;
         d = W'($urandom);
         beat(v, s, d);
         mstep(v, s, d);
         chk_all($sformatf("rnd%0d", i), 2'(m_buf.size() % 4), m_y, m_yv, m_fe, m_pe);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
